// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl_pkg
// Purpose  : Shared definitions for the LED run-control sequencer: the
//            sequencer state encoding and the dir/mode input encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

   // Sequencer states, 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Encodings of the dir input
   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;

   // Encodings of the mode input
   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_WRAP    = 1'b1;

endpackage : led_ctrl_pkg
`default_nettype wire

// File: rtl/led_count_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Prescaler for the LED sequencer. Counts enabled cycles and
//            flags the last cycle of every PRESCALE-cycle period.
// Ports    : clock  - system clock, rising edge
//            reset  - synchronous active-high reset, counter to 0
//            enable - count this cycle (sequencer in RUN)
//            clr    - synchronous counter clear
//            tick   - enable && count == PRESCALE-1 (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
   parameter int PRESCALE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clr,
   output logic tick
);

   // At least one bit so PRESCALE == 1 still yields a legal counter
   localparam int            CW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] c_LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] r_count;

   assign tick = enable && (r_count == c_LAST);

   // Counter holds its value while disabled, which is what lets a paused
   // run resume with the partial period it had already accumulated.
   always_ff @(posedge clock) begin
      if (reset || clr) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= tick ? '0 : r_count + 1'b1;
      end
   end

endmodule : tick_gen
`default_nettype wire

// File: rtl/led_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_count_ctrl
// Purpose  : Run-control sequencer for the LED step counter. Steps a WIDTH-
//            bit LED value up or down once per prescaler tick with start,
//            pause/resume, clear, one-shot and wrap modes.
// Ports    : clock - system clock, rising edge
//            reset - synchronous active-high reset, overrides everything
//            start - pulse: launch from IDLE/DONE, resume from HOLD
//            pause - pulse: RUN -> HOLD
//            clear - pulse: abort to IDLE with LED = 0
//            dir   - 0 count up, 1 count down (sampled on tick / launch)
//            mode  - 0 one-shot, 1 wrap (sampled on tick)
//            LED   - current count, registered
//            busy  - high in RUN and HOLD, registered
//            done  - one-cycle pulse on entry to DONE, registered
// Revision : 1.0 - initial release
// ============================================================================
module led_count_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int PRESCALE = 4,
   parameter int WIDTH    = 6,
   parameter int LIMIT    = 63
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             clear,
   input  logic             dir,
   input  logic             mode,
   output logic [WIDTH-1:0] LED,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_led_nxt;
   logic [WIDTH-1:0] w_step;
   logic             w_terminal;
   logic             w_done_nxt;
   logic             w_tick;
   logic             w_run;
   logic             w_launch;

   assign w_run    = (r_state == ST_RUN);
   // A fresh launch restarts the prescaler period; a resume from HOLD does not.
   assign w_launch = !clear && start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clock  (clock),
      .reset  (reset),
      .enable (w_run),
      .clr    (clear || w_launch),
      .tick   (w_tick)
   );

   // Candidate next LED value for a tick, with wrap at both ends, and
   // whether that value is the terminal value for the current direction.
   // Terminal detection looks only at the landed value, so a mid-run dir
   // change never fires it on its own.
   always_comb begin
      w_step     = LED;
      w_terminal = 1'b0;
      if (dir == DIR_UP) begin
         w_step     = (LED == c_LIMIT) ? '0 : LED + 1'b1;
         w_terminal = (w_step == c_LIMIT);
      end else begin
         w_step     = (LED == '0) ? c_LIMIT : LED - 1'b1;
         w_terminal = (w_step == '0);
      end
   end

   // Next state. Priority: clear > start > pause. A tick coinciding with a
   // pause still applies its step; a one-shot terminal step beats the pause.
   always_comb begin
      w_state_nxt = r_state;
      w_led_nxt   = LED;
      w_done_nxt  = 1'b0;
      if (clear) begin
         w_state_nxt = ST_IDLE;
         w_led_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  w_state_nxt = ST_RUN;
                  w_led_nxt   = (dir == DIR_DOWN) ? c_LIMIT : '0;
               end
            end
            ST_RUN: begin
               if (w_tick) begin
                  w_led_nxt = w_step;
                  if ((mode == MODE_ONESHOT) && w_terminal) begin
                     w_state_nxt = ST_DONE;
                     w_done_nxt  = 1'b1;
                  end else if (pause) begin
                     w_state_nxt = ST_HOLD;
                  end
               end else if (pause) begin
                  w_state_nxt = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (start) begin
                  w_state_nxt = ST_RUN;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_led_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         LED     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         LED     <= w_led_nxt;
         busy    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
         done    <= w_done_nxt;
      end
   end

endmodule : led_count_ctrl
`default_nettype wire
